// File: rtl/dac_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC sample pacer slice. It holds the default
// sample width, the default mid-scale DAC code, the underflow counter width
// and the state type of the pacing state machine.
// ---------------------------------------------------------------------------
package dac_pkg;

    localparam int DAC_DATA_W = 10;
    localparam logic [DAC_DATA_W-1:0] DAC_MIDSCALE = 10'h200;
    localparam int UF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } pacer_state_e;

endpackage

// File: rtl/dac_sample_pacer_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO that buffers core samples ahead of the DAC.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   push, wrData   : write request and data (ignored when full)
//   pop            : read request (ignored when empty)
//   rdData         : head of the FIFO (valid while not empty)
//   full, empty    : occupancy flags
//   level          : current number of stored entries
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wrData,
    input  logic              pop,
    output logic [DATA_W-1:0] rdData,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wrPtr_q;
    logic [PTR_W:0]    rdPtr_q;
    logic              doPush;
    logic              doPop;

    // The extra pointer bit makes the raw difference equal to the occupancy,
    // so full and empty come straight from the level.
    assign level  = wrPtr_q - rdPtr_q;
    assign full   = (level == LVL_W'(FIFO_DEPTH));
    assign empty  = (level == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem_q[rdPtr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: empty entries are never observed.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[PTR_W-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/dac_sample_pacer.sv
// ---------------------------------------------------------------------------
// dac_sample_pacer
// Buffers samples from the core and releases them to the DAC at a fixed,
// programmable period of div+1 clock cycles. On starvation the last code is
// held, the miss is counted and the FIFO re-primes to half full.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : sample input handshake
//   enable                  : run pacing (0 = idle)
//   div                     : sample period minus one
//   dac_code, dac_strobe    : registered DAC code and its update pulse
//   fifo_level              : FIFO occupancy
//   underflow_cnt           : saturating count of missed ticks
//   busy                    : pacer is not idle
// ---------------------------------------------------------------------------
module dac_sample_pacer
    import dac_pkg::*;
#(
    parameter int DATA_W                = DAC_DATA_W,
    parameter int FIFO_DEPTH            = 8,
    parameter int DIV_W                 = 16,
    parameter logic [DATA_W-1:0] MIDSCALE = DAC_MIDSCALE,
    localparam int LVL_W                = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                enable,
    input  logic [DIV_W-1:0]    div,
    output logic [DATA_W-1:0]   dac_code,
    output logic                dac_strobe,
    output logic [LVL_W-1:0]    fifo_level,
    output logic [UF_CNT_W-1:0] underflow_cnt,
    output logic                busy
);

    pacer_state_e        state_q;
    logic [DIV_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   dacCode_q;
    logic                dacStrobe_q;
    logic [UF_CNT_W-1:0] ufCnt_q;
    logic [UF_CNT_W-1:0] ufCnt_d;

    logic                fifoFull;
    logic                fifoEmpty;
    logic [DATA_W-1:0]   fifoHead;
    logic [LVL_W-1:0]    fifoLevel;
    logic                tick;
    logic                popReq;

    sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (in_valid),
        .wrData (in_data),
        .pop    (popReq),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .level  (fifoLevel)
    );

    // Using >= rather than == means a div lowered below the running count
    // ticks at once instead of waiting for the counter to wrap.
    assign tick    = (state_q == ST_RUN) && enable && (cnt_q >= div);
    assign popReq  = tick && !fifoEmpty;
    assign ufCnt_d = (ufCnt_q == '1) ? ufCnt_q : ufCnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dacCode_q   <= MIDSCALE;
            dacStrobe_q <= 1'b0;
            ufCnt_q     <= '0;
        end else begin
            dacStrobe_q <= 1'b0;
            if (!enable) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q   <= '0;
                        state_q <= ST_PRIME;
                    end
                    ST_PRIME: begin
                        cnt_q <= '0;
                        if (fifoLevel >= LVL_W'(FIFO_DEPTH / 2)) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            cnt_q <= '0;
                            if (!fifoEmpty) begin
                                dacCode_q   <= fifoHead;
                                dacStrobe_q <= 1'b1;
                            end else begin
                                // Starved: hold the code and re-prime.
                                ufCnt_q <= ufCnt_d;
                                state_q <= ST_PRIME;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign in_ready      = !fifoFull;
    assign dac_code      = dacCode_q;
    assign dac_strobe    = dacStrobe_q;
    assign fifo_level    = fifoLevel;
    assign underflow_cnt = ufCnt_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_sample_pacer.sv
// ---------------------------------------------------------------------------
// tb_dac_sample_pacer
// Self-checking bench for dac_sample_pacer: a table of directed vectors for
// reset and basic pacing, hand-written multi-cycle corner sequences, and a
// randomized run compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_dac_sample_pacer;

    logic        clk;
    logic        reset;
    logic [9:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        enable;
    logic [15:0] div;
    logic [9:0]  dac_code;
    logic        dac_strobe;
    logic [3:0]  fifo_level;
    logic [7:0]  underflow_cnt;
    logic        busy;

    int compared;
    int mismatched;

    dac_sample_pacer dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .enable        (enable),
        .div           (div),
        .dac_code      (dac_code),
        .dac_strobe    (dac_strobe),
        .fifo_level    (fifo_level),
        .underflow_cnt (underflow_cnt),
        .busy          (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        v;
        logic [9:0]  d;
        logic        en;
        logic [15:0] dv;
        int          cyc;
        logic [9:0]  eCode;
        logic        eStrobe;
        logic [3:0]  eLvl;
        logic        eReady;
        logic        eBusy;
        logic [7:0]  eUf;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: a sample queue plus a coarse mode
    // (0 idle, 1 waiting for half full, 2 pacing).
    int mMode;
    int mCnt;
    int mQ[$];
    int mCode;
    int mStrobe;
    int mUf;

    function automatic void addVec(logic v, logic [9:0] d, logic en, logic [15:0] dv, int cyc,
                                   logic [9:0] eCode, logic eStrobe, logic [3:0] eLvl,
                                   logic eReady, logic eBusy, logic [7:0] eUf);
        vec_t r;
        r.v = v; r.d = d; r.en = en; r.dv = dv; r.cyc = cyc;
        r.eCode = eCode; r.eStrobe = eStrobe; r.eLvl = eLvl;
        r.eReady = eReady; r.eBusy = eBusy; r.eUf = eUf;
        vecs.push_back(r);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and sample 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [9:0] d, input logic en, input logic [15:0] dv);
        in_valid = v;
        in_data  = d;
        enable   = en;
        div      = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        in_data  = '0;
        enable   = 1'b0;
        div      = '0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic void modelReset();
        mMode = 0;
        mCnt = 0;
        mQ.delete();
        mCode = 'h200;
        mStrobe = 0;
        mUf = 0;
    endfunction

    function automatic void modelStep(logic v, int d, logic en, int dv);
        bit doPush;
        doPush = v && (mQ.size() < 8);
        mStrobe = 0;
        if (!en) begin
            mMode = 0;
            mCnt = 0;
        end else if (mMode == 0) begin
            mMode = 1;
        end else if (mMode == 1) begin
            if (mQ.size() >= 4) mMode = 2;
        end else begin
            if (mCnt >= dv) begin
                mCnt = 0;
                if (mQ.size() > 0) begin
                    mCode = mQ.pop_front();
                    mStrobe = 1;
                end else begin
                    if (mUf < 255) mUf++;
                    mMode = 1;
                end
            end else begin
                mCnt++;
            end
        end
        if (doPush) mQ.push_back(d);
    endfunction

    initial begin
        compared   = 0;
        mismatched = 0;
        doReset();

        // ---------------- Table-driven: reset, fill, pace, underflow, re-prime
        addVec(0, 0, 0, 0, 1, 10'h200, 0, 0, 1, 0, 0);
        addVec(1, 1, 0, 0, 1, 10'h200, 0, 1, 1, 0, 0);
        addVec(1, 2, 0, 0, 1, 10'h200, 0, 2, 1, 0, 0);
        addVec(1, 3, 0, 0, 1, 10'h200, 0, 3, 1, 0, 0);
        addVec(1, 4, 0, 0, 1, 10'h200, 0, 4, 1, 0, 0);
        addVec(0, 0, 1, 3, 1, 10'h200, 0, 4, 1, 1, 0);
        addVec(0, 0, 1, 3, 1, 10'h200, 0, 4, 1, 1, 0);
        addVec(0, 0, 1, 3, 3, 10'h200, 0, 4, 1, 1, 0);
        addVec(0, 0, 1, 3, 1, 10'd1,   1, 3, 1, 1, 0);
        addVec(0, 0, 1, 3, 1, 10'd1,   0, 3, 1, 1, 0);
        addVec(0, 0, 1, 3, 3, 10'd2,   1, 2, 1, 1, 0);
        addVec(0, 0, 1, 3, 1, 10'd2,   0, 2, 1, 1, 0);
        addVec(0, 0, 1, 3, 3, 10'd3,   1, 1, 1, 1, 0);
        addVec(0, 0, 1, 3, 1, 10'd3,   0, 1, 1, 1, 0);
        addVec(0, 0, 1, 3, 3, 10'd4,   1, 0, 1, 1, 0);
        addVec(0, 0, 1, 3, 1, 10'd4,   0, 0, 1, 1, 0);
        addVec(0, 0, 1, 3, 3, 10'd4,   0, 0, 1, 1, 1);
        addVec(1, 5, 1, 3, 1, 10'd4,   0, 1, 1, 1, 1);
        addVec(1, 6, 1, 3, 1, 10'd4,   0, 2, 1, 1, 1);
        addVec(1, 7, 1, 3, 1, 10'd4,   0, 3, 1, 1, 1);
        addVec(1, 8, 1, 3, 1, 10'd4,   0, 4, 1, 1, 1);
        addVec(0, 0, 1, 3, 1, 10'd4,   0, 4, 1, 1, 1);
        addVec(0, 0, 1, 3, 3, 10'd4,   0, 4, 1, 1, 1);
        addVec(0, 0, 1, 3, 1, 10'd5,   1, 3, 1, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].cyc) applyStimulus(vecs[i].v, vecs[i].d, vecs[i].en, vecs[i].dv);
            checkOutput($sformatf("vec%0d code", i),   dac_code,      vecs[i].eCode);
            checkOutput($sformatf("vec%0d strobe", i), dac_strobe,    vecs[i].eStrobe);
            checkOutput($sformatf("vec%0d level", i),  fifo_level,    vecs[i].eLvl);
            checkOutput($sformatf("vec%0d ready", i),  in_ready,      vecs[i].eReady);
            checkOutput($sformatf("vec%0d busy", i),   busy,          vecs[i].eBusy);
            checkOutput($sformatf("vec%0d uflow", i),  underflow_cnt, vecs[i].eUf);
        end

        // ---------------- Full FIFO, rejected push, div=0 back-to-back strobes
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 10'(10 + i), 0, 0);
        checkOutput("full ready", in_ready, 0);
        checkOutput("full level", fifo_level, 8);
        applyStimulus(1, 10'd99, 0, 0);
        checkOutput("ninth push level", fifo_level, 8);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput($sformatf("div0 strobe%0d", k), dac_strobe, 1);
            checkOutput($sformatf("div0 code%0d", k), dac_code, 10 + k);
            if (k == 0) begin
                checkOutput("div0 ready after pop", in_ready, 1);
                checkOutput("div0 level after pop", fifo_level, 7);
            end
        end
        applyStimulus(0, 0, 1, 0);
        checkOutput("div0 underflow strobe", dac_strobe, 0);
        checkOutput("div0 underflow code", dac_code, 17);
        checkOutput("div0 underflow cnt", underflow_cnt, 1);

        // ---------------- Async reset mid-run with 5 samples queued
        applyStimulus(0, 0, 0, 3);
        for (int i = 0; i < 8; i++) applyStimulus(1, 10'(40 + i), 0, 3);
        begin
            bit reached;
            reached = 0;
            for (int c = 0; c < 100 && !reached; c++) begin
                applyStimulus(0, 0, 1, 3);
                if (fifo_level == 5) reached = 1;
            end
            checkOutput("reach level 5", reached, 1);
        end
        checkOutput("pre-reset code", dac_code, 42);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset code", dac_code, 10'h200);
        checkOutput("async reset level", fifo_level, 0);
        checkOutput("async reset uflow", underflow_cnt, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset ready", in_ready, 1);
        checkOutput("async reset strobe", dac_strobe, 0);
        #2 reset = 1'b1;
        applyStimulus(0, 0, 0, 0);

        // ---------------- div lowered below the running count
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 10'(21 + i), 0, 100);
        applyStimulus(0, 0, 1, 100);
        applyStimulus(0, 0, 1, 100);
        repeat (50) applyStimulus(0, 0, 1, 100);
        checkOutput("div100 no tick yet", dac_strobe, 0);
        applyStimulus(0, 0, 1, 10);
        checkOutput("div shrink immediate tick", dac_strobe, 1);
        checkOutput("div shrink code", dac_code, 21);
        begin
            int strobes;
            strobes = 0;
            repeat (10) begin
                applyStimulus(0, 0, 1, 10);
                strobes += dac_strobe;
            end
            checkOutput("div10 quiet cycles", strobes, 0);
        end
        applyStimulus(0, 0, 1, 10);
        checkOutput("div10 period tick", dac_strobe, 1);
        checkOutput("div10 period code", dac_code, 22);

        // ---------------- Underflow saturation
        doReset();
        for (int it = 1; it <= 300; it++) begin
            repeat (4) applyStimulus(1, it[9:0], 1, 0);
            repeat (12) applyStimulus(0, 0, 1, 0);
            if (it == 1 || it == 254 || it == 255 || it == 300)
                checkOutput($sformatf("uflow after %0d", it), underflow_cnt, (it > 255) ? 255 : it);
        end

        // ---------------- Randomized run against the reference model
        doReset();
        modelReset();
        begin
            logic        rEn;
            logic [15:0] rDiv;
            int          pct;
            rEn  = 1;
            rDiv = 2;
            pct  = 50;
            for (int c = 0; c < 3000; c++) begin
                logic       rV;
                logic [9:0] rD;
                if (c % 200 == 0) pct = (c / 200 % 3 == 0) ? 20 : ((c / 200 % 3 == 1) ? 50 : 90);
                if ($urandom_range(0, 99) < 2) rEn = ~rEn;
                if ($urandom_range(0, 99) < 5) rDiv = 16'($urandom_range(0, 4));
                rV = ($urandom_range(0, 99) < pct);
                rD = 10'($urandom);
                modelStep(rV, rD, rEn, rDiv);
                applyStimulus(rV, rD, rEn, rDiv);
                checkOutput($sformatf("rnd%0d code", c),   dac_code,      mCode);
                checkOutput($sformatf("rnd%0d strobe", c), dac_strobe,    mStrobe);
                checkOutput($sformatf("rnd%0d level", c),  fifo_level,    mQ.size());
                checkOutput($sformatf("rnd%0d ready", c),  in_ready,      (mQ.size() < 8));
                checkOutput($sformatf("rnd%0d busy", c),   busy,          (mMode != 0));
                checkOutput($sformatf("rnd%0d uflow", c),  underflow_cnt, mUf);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
